// File: rtl/snn_pkg.sv
// Shared definitions for the SNN neuron engine: opcodes, FSM states and the adder.
// Build option SNN_SAT_EN selects a saturating add instead of two's-complement wrap.
package snn_pkg;

    localparam logic [1:0] OP_ACC = 2'b00;
    localparam logic [1:0] OP_INT = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Operands arrive sign-extended to 64 bits; the result is bounded to a w-bit signed range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned       w);
        logic signed [63:0] sum;
        logic signed [63:0] res;
        sum = a + b;
`ifdef SNN_SAT_EN
        res = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        if (sum > res) begin
            res = res;
        end else if (sum < (-res - 64'sd1)) begin
            res = -res - 64'sd1;
        end else begin
            res = sum;
        end
`else
        res = (sum <<< (32'd64 - w)) >>> (32'd64 - w);
`endif
        return res;
    endfunction

endpackage

// File: rtl/snn_lane.sv
// Combinational single-neuron update: accumulate, leaky integrate-and-fire, or clear.
module snn_lane
    import snn_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [1:0]               i_op,
    input  logic signed [DATA_W-1:0] i_cur,
    input  logic signed [DATA_W-1:0] i_vol,
    input  logic signed [DATA_W-1:0] i_w,
    input  logic                     i_s,
    input  logic signed [DATA_W-1:0] i_vt,
    output logic signed [DATA_W-1:0] o_cur,
    output logic signed [DATA_W-1:0] o_vol,
    output logic                     o_spike
);

    logic signed [DATA_W-1:0] w_leak;
    logic signed [DATA_W-1:0] w_vdec;
    logic signed [DATA_W-1:0] w_acc;
    logic signed [DATA_W-1:0] w_vnew;

    // Next-state selection for one neuron
    always_comb begin
        w_leak  = i_vol >>> LEAK_SHIFT;
        w_vdec  = i_vol - w_leak;
        w_acc   = DATA_W'(sat_add(64'(i_cur), i_s ? 64'(i_w) : 64'sd0, DATA_W));
        w_vnew  = DATA_W'(sat_add(64'(w_vdec), 64'(i_cur), DATA_W));
        o_cur   = i_cur;
        o_vol   = i_vol;
        o_spike = 1'b0;
        case (i_op)
            OP_ACC: begin
                o_cur = w_acc;
            end
            OP_INT: begin
                o_cur = '0;
                if (w_vnew >= i_vt) begin
                    o_spike = 1'b1;
                    o_vol   = '0;
                end else begin
                    o_spike = 1'b0;
                    o_vol   = w_vnew;
                end
            end
            OP_CLR: begin
                o_cur = '0;
                o_vol = '0;
            end
            default: begin
                o_cur = i_cur;
                o_vol = i_vol;
            end
        endcase
    end

endmodule

// File: rtl/snn_neuron_engine.sv
// Multi-cycle neuron state engine: updates LANES neurons per beat and stalls the pipeline via busy.
// Optional build macro SNN_SAT_EN switches the accumulate/integrate adders to saturation.
module snn_neuron_engine
    import snn_pkg::*;
#(
    parameter int NEURONS    = 16,
    parameter int LANES      = 4,
    parameter int DATA_W     = 32,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [1:0]                  op,
    input  logic [NEURONS*DATA_W-1:0]   w_in,
    input  logic [NEURONS-1:0]          s_in,
    input  logic [DATA_W-1:0]           vt_in,
    input  logic [$clog2(NEURONS)-1:0]  rd_idx,
    output logic [DATA_W-1:0]           cur_rd,
    output logic [DATA_W-1:0]           vol_rd,
    output logic [NEURONS-1:0]          spike_out,
    output logic                        busy,
    output logic                        done
);

    localparam int BEATS  = NEURONS / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W  = (NEURONS > 1) ? $clog2(NEURONS) : 1;

    if (NEURONS % LANES != 0) begin : g_bad_lanes
        $error("NEURONS must be a multiple of LANES");
    end
    if (DATA_W > 62) begin : g_bad_width
        $error("DATA_W must not exceed 62");
    end

    state_t                   r_state;
    logic [BEAT_W-1:0]        r_beat;
    logic [1:0]               r_op;
    logic [NEURONS*DATA_W-1:0] r_w;
    logic [NEURONS-1:0]       r_s;
    logic signed [DATA_W-1:0] r_vt;
    logic signed [DATA_W-1:0] r_cur [NEURONS];
    logic signed [DATA_W-1:0] r_vol [NEURONS];
    logic [NEURONS-1:0]       r_shadow;
    logic [NEURONS-1:0]       r_spike;
    logic                     r_busy;
    logic                     r_done;

    logic [IDX_W-1:0]         w_idx [LANES];
    logic signed [DATA_W-1:0] w_cur_out [LANES];
    logic signed [DATA_W-1:0] w_vol_out [LANES];
    logic [LANES-1:0]         w_spike;
    logic [NEURONS-1:0]       w_shadow_next;

    // Neuron indices served by each lane in the current beat
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_idx[l] = IDX_W'(int'(r_beat) * LANES + l);
        end
    end

    // Shadow spike vector with this beat's lane results merged in
    always_comb begin
        w_shadow_next = r_shadow;
        for (int l = 0; l < LANES; l++) begin
            w_shadow_next[w_idx[l]] = w_spike[l];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        snn_lane #(
            .DATA_W     (DATA_W),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .i_op    (r_op),
            .i_cur   (r_cur[w_idx[g]]),
            .i_vol   (r_vol[w_idx[g]]),
            .i_w     (r_w[w_idx[g]*DATA_W +: DATA_W]),
            .i_s     (r_s[w_idx[g]]),
            .i_vt    (r_vt),
            .o_cur   (w_cur_out[g]),
            .o_vol   (w_vol_out[g]),
            .o_spike (w_spike[g])
        );
    end

    // Control FSM, operand capture and neuron state write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_beat   <= '0;
            r_op     <= OP_NOP;
            r_w      <= '0;
            r_s      <= '0;
            r_vt     <= '0;
            r_shadow <= '0;
            r_spike  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < NEURONS; i++) begin
                r_cur[i] <= '0;
                r_vol[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op    <= op;
                        r_w     <= w_in;
                        r_s     <= s_in;
                        r_vt    <= vt_in;
                        r_beat  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_cur[w_idx[l]] <= w_cur_out[l];
                        r_vol[w_idx[l]] <= w_vol_out[l];
                    end
                    r_shadow <= w_shadow_next;
                    r_beat   <= r_beat + BEAT_W'(1);
                    if (r_beat == BEAT_W'(BEATS - 1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        // Only firing-related ops publish a new spike vector
                        if ((r_op == OP_INT) || (r_op == OP_CLR)) begin
                            r_spike <= w_shadow_next;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cur_rd    = r_cur[rd_idx];
    assign vol_rd    = r_vol[rd_idx];
    assign spike_out = r_spike;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_snn_neuron_engine.sv
// Scoreboard bench for snn_neuron_engine: driver pushes expectations, monitor compares on done/read strobes.
module tb_snn_neuron_engine;

    localparam int N  = 16;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b11;
    logic [N*DW-1:0] w_in = '0;
    logic [N-1:0]    s_in = '0;
    logic [DW-1:0]   vt_in = '0;
    logic [3:0]      rd_idx = '0;
    logic [DW-1:0]   cur_rd, vol_rd;
    logic [N-1:0]    spike_out;
    logic            busy, done;

    snn_neuron_engine dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .w_in(w_in), .s_in(s_in),
        .vt_in(vt_in), .rd_idx(rd_idx), .cur_rd(cur_rd), .vol_rd(vol_rd),
        .spike_out(spike_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_cur [N];
    logic [DW-1:0] m_vol [N];
    logic [N-1:0]  m_spk = '0;

    logic [N-1:0]  exp_spk_q [$];
    logic [DW-1:0] exp_cur_q [$];
    logic [DW-1:0] exp_vol_q [$];
    logic          rd_vld = 1'b0;

    function automatic logic [DW-1:0] madd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef SNN_SAT_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic logic [N*DW-1:0] wfill(input logic [DW-1:0] v);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [N*DW-1:0] winc();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(i + 1);
        return r;
    endfunction

    task automatic model(input logic [1:0] o, input logic [N*DW-1:0] w,
                         input logic [N-1:0] s, input logic [DW-1:0] vt);
        logic [DW-1:0] dec, v;
        for (int i = 0; i < N; i++) begin
            case (o)
                2'b00: if (s[i]) m_cur[i] = madd(m_cur[i], w[i*DW +: DW]);
                2'b01: begin
                    dec = m_vol[i] - 32'($signed(m_vol[i]) >>> 3);
                    v   = madd(dec, m_cur[i]);
                    if ($signed(v) >= $signed(vt)) begin
                        m_spk[i] = 1'b1;
                        m_vol[i] = '0;
                    end else begin
                        m_spk[i] = 1'b0;
                        m_vol[i] = v;
                    end
                    m_cur[i] = '0;
                end
                2'b10: begin
                    m_cur[i] = '0;
                    m_vol[i] = '0;
                    m_spk[i] = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    // Monitor: checks spike_out on every done pulse and state reads on every read strobe
    always @(negedge clk) begin
        if (done) begin
            n_vec++;
            if (exp_spk_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got done=1 spike_out=%h, expected no done", spike_out);
            end else begin
                logic [N-1:0] e;
                e = exp_spk_q.pop_front();
                if (spike_out !== e) begin
                    n_err++;
                    $display("FAIL spike_out: got %h expected %h", spike_out, e);
                end
            end
        end
        if (rd_vld) begin
            logic [DW-1:0] ec, ev;
            ec = exp_cur_q.pop_front();
            ev = exp_vol_q.pop_front();
            n_vec++;
            if (cur_rd !== ec || vol_rd !== ev) begin
                n_err++;
                $display("FAIL state_rd[%0d]: got cur=%h vol=%h expected cur=%h vol=%h",
                         rd_idx, cur_rd, vol_rd, ec, ev);
            end
        end
    end

    task automatic sweep();
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            rd_idx = 4'(i);
            rd_vld = 1'b1;
            exp_cur_q.push_back(m_cur[i]);
            exp_vol_q.push_back(m_vol[i]);
        end
        @(posedge clk); #1;
        rd_vld = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [N*DW-1:0] w,
                          input logic [N-1:0] s, input logic [DW-1:0] vt, input bit spam);
        int cnt;
        @(posedge clk); #1;
        op = o; w_in = w; s_in = s; vt_in = vt; start = 1'b1;
        model(o, w, s, vt);
        exp_spk_q.push_back(m_spk);
        @(posedge clk); #1;
        start = spam;
        w_in = ~w; s_in = ~s; vt_in = ~vt; op = ~o;
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_vec++;
        if (cnt != 5) begin
            n_err++;
            $display("FAIL busy_len: got %0d cycles expected 5", cnt);
        end
        n_vec++;
        if (exp_spk_q.size() != 0) begin
            n_err++;
            $display("FAIL done_missing: got %0d pending expected 0", exp_spk_q.size());
            exp_spk_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            m_cur[i] = '0;
            m_vol[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || spike_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b spike=%h expected 0 0 0000", busy, done, spike_out);
        end
        sweep();

        run_op(2'b00, winc(), 16'hFFFF, 32'd0, 1'b0);
        sweep();

        run_op(2'b10, '0, '0, '0, 1'b0);
        run_op(2'b00, wfill(32'd8), 16'hFFFF, 32'd0, 1'b0);
        run_op(2'b01, '0, '0, 32'd8, 1'b0);
        sweep();
        run_op(2'b00, wfill(32'd8), 16'hFFFF, 32'd0, 1'b0);
        run_op(2'b01, '0, '0, 32'd9, 1'b0);
        sweep();
        run_op(2'b00, wfill(32'd8), 16'hFFFF, 32'd0, 1'b0);
        run_op(2'b01, '0, '0, 32'd9, 1'b0);
        sweep();

        run_op(2'b10, '0, '0, '0, 1'b0);
        run_op(2'b00, wfill(32'd3), 16'hA5A5, 32'd0, 1'b1);
        sweep();
        run_op(2'b01, '0, '0, 32'd2, 1'b0);
        run_op(2'b00, wfill(32'd7), 16'hFFFF, 32'd0, 1'b0);
        run_op(2'b11, wfill(32'd9), 16'hFFFF, 32'd0, 1'b0);
        sweep();

        // Abort an ACC in its third beat
        @(posedge clk); #1;
        op = 2'b00; w_in = wfill(32'd5); s_in = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || spike_out !== 16'h0000) begin
            n_err++;
            $display("FAIL abort_reset: got busy=%b done=%b spike=%h expected 0 0 0000", busy, done, spike_out);
        end
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_cur[i] = '0;
            m_vol[i] = '0;
        end
        m_spk = '0;
        sweep();
        run_op(2'b00, winc(), 16'h00FF, 32'd0, 1'b0);
        sweep();

        run_op(2'b10, '0, '0, '0, 1'b0);
        run_op(2'b00, wfill(32'h7FFF_FFF0), 16'h0001, 32'd0, 1'b0);
        run_op(2'b00, wfill(32'h0000_0020), 16'h0001, 32'd0, 1'b0);
        @(posedge clk); #1;
        rd_idx = 4'd0;
        #1;
        n_vec++;
`ifdef SNN_SAT_EN
        if (cur_rd !== 32'h7FFF_FFFF) begin
            n_err++;
            $display("FAIL sat_add: got %h expected 7fffffff", cur_rd);
        end
`else
        if (cur_rd !== 32'h8000_0010) begin
            n_err++;
            $display("FAIL wrap_add: got %h expected 80000010", cur_rd);
        end
`endif
        sweep();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snn_neuron_engine.md
# snn_neuron_engine

Parametrised, multi-cycle neuron update engine for the neuromorphic extension of the 5-stage RISC-V core. It holds NEURONS current/voltage state words and processes them LANES at a time. Supported operations are spike-gated weight accumulation, leaky integrate-and-fire, and clear. It sits in the execute stage and raises `busy` so the hazard logic holds the pipeline until `done`.

## Interface
Parameters:
- NEURONS, 16, neurons held in state; must be a multiple of LANES (elaboration error otherwise)
- LANES, 4, neurons updated per cycle
- DATA_W, 32, signed width of weight, current, voltage and threshold
- LEAK_SHIFT, 3, voltage leak is `vol >>> LEAK_SHIFT` (arithmetic shift)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  launch request; sampled only in IDLE
- op  in  2  operation: 00 ACC, 01 INT, 10 CLR, 11 NOP
- w_in  in  NEURONS*DATA_W  weights; neuron i at bits [i*DATA_W +: DATA_W]; captured at start
- s_in  in  NEURONS  input spikes, bit i belongs to neuron i; captured at start
- vt_in  in  DATA_W  firing threshold, signed; captured at start
- rd_idx  in  $clog2(NEURONS)  state read index
- cur_rd  out  DATA_W  current of neuron rd_idx (combinational)
- vol_rd  out  DATA_W  voltage of neuron rd_idx (combinational)
- spike_out  out  NEURONS  registered spike vector from the last INT or CLR
- busy  out  1  high whenever the FSM is not in IDLE; drives the pipeline stall
- done  out  1  one-cycle completion pulse

## Operation
- Reset: FSM goes to IDLE. All cur[i], vol[i], spike_out, busy and done are 0. The beat counter is 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`. In that cycle w_in, s_in, vt_in and op are captured and the beat counter is set to 0.
  - RUN: each cycle, neurons beat*LANES … beat*LANES+LANES-1 are updated and the counter increments. After beat BEATS-1 (BEATS = NEURONS/LANES) the FSM goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. It is neither queued nor counted.
- ACC: cur[i] ← cur[i] + (s[i] ? w[i] : 0). vol and spike_out are unchanged.
- INT:
  - v' = vol[i] − (vol[i] >>> LEAK_SHIFT) + cur[i].
  - If v' ≥ vt (signed compare): spike bit i = 1 and vol[i] ← 0. Otherwise spike bit i = 0 and vol[i] ← v'.
  - cur[i] ← 0.
- CLR: cur[i], vol[i] and spike bit i are set to 0.
- NOP: runs the full sequence with no state change.
- spike_out: spike bits are collected into a shadow vector during RUN. spike_out is loaded from the shadow on entry to DONE, and only for INT and CLR.
- Arithmetic: the add in ACC and the add in INT use the DATA_W adder behaviour selected under Configuration. Leak subtraction cannot overflow and is plain.
- Reads: during RUN, cur_rd/vol_rd show partially updated state. This is defined, legal behaviour.
- Reset mid-operation: aborts immediately. All state is zeroed and no done pulse is issued.

## Timing
- `start` sampled at edge T (IDLE) → busy=1 from T to T+BEATS+1.
- State updates at edges T+1 … T+BEATS.
- done=1 during the cycle following edge T+BEATS. busy drops at edge T+BEATS+1.
- With defaults: busy is high for 5 cycles and done arrives 5 cycles after start.
- Back-to-back: earliest accepted next start is the cycle after done, giving BEATS+2 cycles per op.
- No combinational path from start to busy. busy is registered state decode.

## Configuration
- SNN_SAT_EN defined: adds saturate to +2^(DATA_W-1)−1 / −2^(DATA_W-1).
- SNN_SAT_EN undefined: adds wrap in two's complement.

## Structure
- Package snn_pkg holds:
  - op encoding constants (OP_ACC, OP_INT, OP_CLR, OP_NOP)
  - FSM state typedef
  - `sat_add` function, guarded by SNN_SAT_EN
- Sub-module snn_lane: combinational single-neuron update taking op, cur, vol, w, s, vt and returning cur', vol', spike. It is instantiated LANES times. Top level holds the FSM, counter, state arrays and capture registers.

## Test plan
All scenarios use default parameters.
- Reset held 2 cycles → busy=0, done=0, spike_out=0; cur_rd=vol_rd=0 for every rd_idx 0–15.
- ACC with s_in=16'hFFFF, w[i]=i+1 → busy high 5 cycles, single done; cur_rd(i)=i+1, vol unchanged.
- ACC (w=8, s all 1), then INT vt=8 → spike_out=16'hFFFF, vol=0, cur=0. Repeat with vt=9 → spike_out=0, vol=8. Then ACC w=8 + INT vt=9 → vol' = 8−1+8 = 15, spike_out=16'hFFFF, vol=0.
- start pulsed on every cycle of a running ACC → exactly one done; state reflects a single accumulation.
- cur[0]=32'h7FFFFFF0, then ACC w[0]=32'h20 → 32'h7FFFFFFF with SNN_SAT_EN, 32'h80000010 without.
- reset asserted during beat 2 of an ACC → next cycle busy=0, all cur/vol/spike_out 0, no done pulse; next start executes normally.
